// File: rtl/ahb_slave_iface_if.sv
// AHB-Lite bus bundle between a bus master and the edge-detector slave interface.
// The master modport drives the address/data phase; the slave modport returns the response.
interface ahb_slave_iface_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              ahb_hsel;
    logic [1:0]        ahb_htrans;
    logic              ahb_hwrite;
    logic [2:0]        ahb_hsize;
    logic [ADDR_W-1:0] ahb_haddr;
    logic [DATA_W-1:0] ahb_hwdata;
    logic              ahb_hready;
    logic [DATA_W-1:0] ahb_hrdata;
    logic              ahb_hreadyout;
    logic              ahb_hresp;

    modport master (
        output ahb_hsel, ahb_htrans, ahb_hwrite, ahb_hsize, ahb_haddr, ahb_hwdata, ahb_hready,
        input  ahb_hrdata, ahb_hreadyout, ahb_hresp
    );

    modport slave (
        input  ahb_hsel, ahb_htrans, ahb_hwrite, ahb_hsize, ahb_haddr, ahb_hwdata, ahb_hready,
        output ahb_hrdata, ahb_hreadyout, ahb_hresp
    );
endinterface

// File: rtl/ahb_slave_iface.sv
// AHB-Lite slave: pixel FIFO push port, status word, FIFO level/flush and config registers.
// Stalls pushes into a full FIFO and answers illegal accesses with a two-cycle ERROR.
module ahb_slave_iface #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_REGS   = 4
) (
    input  logic                       ahb_hclk,
    input  logic                       ahb_hresetn,
    ahb_slave_iface_if.slave           bus,
    output logic [DATA_W-1:0]          pix_data,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    input  logic [DATA_W-1:0]          status_in,
    output logic [NUM_REGS*DATA_W-1:0] cfg_regs
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2:0]       SIZE_ENC  = 3'($clog2(DATA_W / 8));
    localparam logic [IDX_W-1:0] IDX_PUSH  = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_STAT  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LEVEL = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(3 + NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        OKAY_ST   = 2'd0,
        WAIT_FULL = 2'd1,
        ERR1      = 2'd2,
        ERR2      = 2'd3
    } state_t;

    state_t                          state_r;
    state_t                          state_nxt_s;
    logic                            dp_valid_r;
    logic                            dp_write_r;
    logic [IDX_W-1:0]                dp_idx_r;
    logic [DATA_W-1:0]               mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]                wr_ptr_r;
    logic [PTR_W-1:0]                rd_ptr_r;
    logic [CNT_W-1:0]                count_r;
    logic [NUM_REGS-1:0][DATA_W-1:0] cfg_r;

    logic [IDX_W-1:0]  idx_s;
    logic              cap_s;
    logic              legal_s;
    logic              err_cap_s;
    logic              pop_s;
    logic              can_accept_s;
    logic              dp_push_s;
    logic              push_s;
    logic              flush_s;
    logic              hreadyout_s;
    logic              hresp_s;
    logic [DATA_W-1:0] hrdata_s;
    logic              unused_s;

    assign idx_s     = bus.ahb_haddr[ADDR_W-1:2];
    assign cap_s     = bus.ahb_hsel & bus.ahb_htrans[1] & bus.ahb_hready;
    assign err_cap_s = cap_s & ~legal_s;
    assign unused_s  = bus.ahb_htrans[0];

    assign pix_valid    = (count_r != {CNT_W{1'b0}});
    assign pix_data     = mem_r[rd_ptr_r];
    assign pop_s        = pix_valid & pix_ready;
    assign can_accept_s = (count_r != CNT_FULL) | pop_s;
    assign dp_push_s    = dp_valid_r & dp_write_r & (dp_idx_r == IDX_PUSH);
    assign push_s       = dp_push_s & can_accept_s;
    assign flush_s      = dp_valid_r & dp_write_r & (dp_idx_r == IDX_LEVEL);
    assign cfg_regs     = cfg_r;

    assign bus.ahb_hreadyout = hreadyout_s;
    assign bus.ahb_hresp     = hresp_s;
    assign bus.ahb_hrdata    = hrdata_s;

    // Address-phase legality check
    always_comb begin
        legal_s = 1'b1;
        if (bus.ahb_hsize != SIZE_ENC) begin
            legal_s = 1'b0;
        end else if (bus.ahb_haddr[1:0] != 2'b00) begin
            legal_s = 1'b0;
        end else if (idx_s >= IDX_END) begin
            legal_s = 1'b0;
        end else if (!bus.ahb_hwrite && (idx_s == IDX_PUSH)) begin
            legal_s = 1'b0;
        end else if (bus.ahb_hwrite && (idx_s == IDX_STAT)) begin
            legal_s = 1'b0;
        end else begin
            legal_s = 1'b1;
        end
    end

    // Address-phase capture; illegal transfers never become an active data phase
    always_ff @(posedge ahb_hclk or negedge ahb_hresetn) begin
        if (!ahb_hresetn) begin
            dp_valid_r <= 1'b0;
            dp_write_r <= 1'b0;
            dp_idx_r   <= {IDX_W{1'b0}};
        end else if (bus.ahb_hready) begin
            dp_valid_r <= cap_s & legal_s;
            dp_write_r <= bus.ahb_hwrite;
            dp_idx_r   <= idx_s;
        end
    end

    // Data-phase state register
    always_ff @(posedge ahb_hclk or negedge ahb_hresetn) begin
        if (!ahb_hresetn) begin
            state_r <= OKAY_ST;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Data-phase next-state logic
    always_comb begin
        state_nxt_s = OKAY_ST;
        case (state_r)
            OKAY_ST, WAIT_FULL: begin
                if (dp_push_s && !can_accept_s) begin
                    state_nxt_s = WAIT_FULL;
                end else if (err_cap_s) begin
                    state_nxt_s = ERR1;
                end else begin
                    state_nxt_s = OKAY_ST;
                end
            end
            ERR1:    state_nxt_s = ERR2;
            ERR2: begin
                if (err_cap_s) begin
                    state_nxt_s = ERR1;
                end else begin
                    state_nxt_s = OKAY_ST;
                end
            end
            default: state_nxt_s = OKAY_ST;
        endcase
    end

    // Data-phase response outputs; a blocked push holds the bus until space appears
    always_comb begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
        case (state_r)
            OKAY_ST, WAIT_FULL: begin
                hreadyout_s = dp_push_s ? can_accept_s : 1'b1;
                hresp_s     = 1'b0;
            end
            ERR1: begin
                hreadyout_s = 1'b0;
                hresp_s     = 1'b1;
            end
            ERR2: begin
                hreadyout_s = 1'b1;
                hresp_s     = 1'b1;
            end
            default: begin
                hreadyout_s = 1'b1;
                hresp_s     = 1'b0;
            end
        endcase
    end

    // Read data mux from the captured word index
    always_comb begin
        hrdata_s = {DATA_W{1'b0}};
        if (dp_valid_r && !dp_write_r) begin
            if (dp_idx_r == IDX_STAT) begin
                hrdata_s = status_in;
            end else if (dp_idx_r == IDX_LEVEL) begin
                hrdata_s = DATA_W'(count_r);
            end else begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (dp_idx_r == IDX_W'(3 + k)) begin
                        hrdata_s = cfg_r[k];
                    end else begin
                        hrdata_s = hrdata_s;
                    end
                end
            end
        end else begin
            hrdata_s = {DATA_W{1'b0}};
        end
    end

    // Pixel FIFO; flush overrides a same-cycle pop
    always_ff @(posedge ahb_hclk or negedge ahb_hresetn) begin
        if (!ahb_hresetn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (flush_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.ahb_hwdata;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Configuration registers
    always_ff @(posedge ahb_hclk or negedge ahb_hresetn) begin
        if (!ahb_hresetn) begin
            cfg_r <= {(NUM_REGS*DATA_W){1'b0}};
        end else if (dp_valid_r && dp_write_r) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (dp_idx_r == IDX_W'(3 + k)) begin
                    cfg_r[k] <= bus.ahb_hwdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_slave_iface.sv
// Self-checking bench for ahb_slave_iface: vector table for register/error accesses,
// scoreboard of expected responses, and hand sequences for FIFO stall, flush and reset.
module tb_ahb_slave_iface;
    logic         clk;
    logic         rst_n;
    logic [31:0]  pix_data;
    logic         pix_valid;
    logic         pix_ready;
    logic [31:0]  status_in;
    logic [127:0] cfg_regs;
    int           n_checks;
    int           n_fail;

    typedef struct {
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
        int          waits;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[13];

    ahb_slave_iface_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    assign bus.ahb_hready = bus.ahb_hreadyout;

    ahb_slave_iface #(.DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(8), .NUM_REGS(4)) dut (
        .ahb_hclk    (clk),
        .ahb_hresetn (rst_n),
        .bus         (bus.slave),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .status_in   (status_in),
        .cfg_regs    (cfg_regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.ahb_hsel   = 1'b0;
        bus.ahb_htrans = 2'b00;
        bus.ahb_hwrite = 1'b0;
        bus.ahb_hsize  = 3'b010;
        bus.ahb_haddr  = 32'h0;
    endtask

    // One non-pipelined transfer; expectation queued at address phase, checked at completion
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic exp_err, input logic chk_rd,
                        input logic [31:0] exp_rd, input int exp_waits);
        exp_t        e;
        exp_t        x;
        int          waits;
        logic        first_resp;
        logic        got_resp;
        logic [31:0] got_rd;
        e.err = exp_err; e.chk_rd = chk_rd; e.rd = exp_rd; e.waits = exp_waits;
        sb_q.push_back(e);
        @(negedge clk);
        bus.ahb_hsel   = 1'b1;
        bus.ahb_htrans = 2'b10;
        bus.ahb_hwrite = wr;
        bus.ahb_haddr  = addr;
        bus.ahb_hsize  = size;
        @(posedge clk);
        #1;
        bus_idle();
        bus.ahb_hwdata = wdata;
        waits      = 0;
        first_resp = 1'b0;
        @(negedge clk);
        while (!bus.ahb_hreadyout && waits < 40) begin
            if (waits == 0) first_resp = bus.ahb_hresp;
            waits++;
            @(negedge clk);
        end
        got_resp = bus.ahb_hresp;
        got_rd   = bus.ahb_hrdata;
        x = sb_q.pop_front();
        check("hresp", 64'(got_resp), 64'(x.err));
        check("wait_states", 64'(waits), 64'(x.waits));
        if (x.err) check("err_first_cycle_hresp", 64'(first_resp), 64'h1);
        if (x.chk_rd) check("hrdata", 64'(got_rd), 64'(x.rd));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        pix_ready = 1'b0;
        status_in = 32'hDEAD_BEEF;
        bus.ahb_hwdata = 32'h0;
        bus_idle();

        //            wr    addr   size   wdata         err   chk   exp_rd
        vecs[0]  = '{1'b1, 32'hC,  3'd2, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'hC,  3'd2, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001};
        vecs[2]  = '{1'b1, 32'h18, 3'd2, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h18, 3'd2, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
        vecs[4]  = '{1'b0, 32'h4,  3'd2, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 32'h8,  3'd2, 32'h0,         1'b0, 1'b1, 32'h0};
        vecs[6]  = '{1'b0, 32'h0,  3'd2, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 32'h4,  3'd2, 32'h7777_7777, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'hC,  3'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h2,  3'd2, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h1C, 3'd2, 32'h0,         1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'hC,  3'd2, 32'h0,         1'b0, 1'b1, 32'hA5A5_0001};
        vecs[12] = '{1'b0, 32'h8,  3'd2, 32'h0,         1'b0, 1'b1, 32'h0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_hreadyout", 64'(bus.ahb_hreadyout), 64'h1);
        check("rst_hresp", 64'(bus.ahb_hresp), 64'h0);
        check("rst_hrdata", 64'(bus.ahb_hrdata), 64'h0);
        check("rst_pix_valid", 64'(pix_valid), 64'h0);
        check("rst_cfg_lo", cfg_regs[63:0], 64'h0);
        check("rst_cfg_hi", cfg_regs[127:64], 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Register, status, level and illegal-access vectors
        for (int i = 0; i < 13; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
                 vecs[i].exp_err, vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_err ? 1 : 0);
        end
        check("cfg0_after_vecs", 64'(cfg_regs[31:0]), 64'hA5A5_0001);
        check("cfg3_after_vecs", 64'(cfg_regs[127:96]), 64'h1234_5678);
        check("cfg1_untouched", 64'(cfg_regs[63:32]), 64'h0);
        check("fifo_empty_after_errs", 64'(pix_valid), 64'h0);

        // Fill FIFO with 1..8, then a ninth push stalls until one pop
        for (int i = 1; i <= 8; i++) xfer(1'b1, 32'h0, 3'd2, 32'(i), 1'b0, 1'b0, 32'h0, 0);
        xfer(1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 1'b1, 32'd8, 0);
        check("full_head", 64'(pix_data), 64'd1);
        @(negedge clk);
        bus.ahb_hsel = 1'b1; bus.ahb_htrans = 2'b10; bus.ahb_hwrite = 1'b1; bus.ahb_haddr = 32'h0;
        @(posedge clk);
        #1;
        bus_idle();
        bus.ahb_hwdata = 32'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hreadyout", 64'(bus.ahb_hreadyout), 64'h0);
            check("stall_hresp", 64'(bus.ahb_hresp), 64'h0);
        end
        pix_ready = 1'b1;
        #1;
        check("stall_release_hreadyout", 64'(bus.ahb_hreadyout), 64'h1);
        @(posedge clk);
        #1;
        pix_ready = 1'b0;
        @(negedge clk);
        check("head_after_pop", 64'(pix_data), 64'd2);
        xfer(1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 1'b1, 32'd8, 0);

        // Full FIFO with pops: back-to-back pushes 10..13 never wait
        @(negedge clk);
        bus.ahb_hsel = 1'b1; bus.ahb_htrans = 2'b10; bus.ahb_hwrite = 1'b1; bus.ahb_haddr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) pix_ready = 1'b1;
            bus.ahb_hwdata = 32'(10 + i);
            if (i == 3) bus_idle();
            @(negedge clk);
            check("b2b_hreadyout", 64'(bus.ahb_hreadyout), 64'h1);
        end
        @(posedge clk);
        #1;
        pix_ready = 1'b0;
        check("b2b_head", 64'(pix_data), 64'd6);
        xfer(1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 1'b1, 32'd8, 0);

        // Drain to 5 entries, then flush while popping
        pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pix_ready = 1'b0;
        check("five_head", 64'(pix_data), 64'd9);
        xfer(1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 1'b1, 32'd5, 0);
        pix_ready = 1'b1;
        xfer(1'b1, 32'h8, 3'd2, 32'hFFFF_0000, 1'b0, 1'b0, 32'h0, 0);
        check("flush_pix_valid", 64'(pix_valid), 64'h0);
        pix_ready = 1'b0;
        xfer(1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 1'b1, 32'd0, 0);

        // Reset asserted while a push is stalled
        status_in = 32'h0000_CAFE;
        xfer(1'b0, 32'h4, 3'd2, 32'h0, 1'b0, 1'b1, 32'h0000_CAFE, 0);
        for (int i = 0; i < 8; i++) xfer(1'b1, 32'h0, 3'd2, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0, 0);
        @(negedge clk);
        bus.ahb_hsel = 1'b1; bus.ahb_htrans = 2'b10; bus.ahb_hwrite = 1'b1; bus.ahb_haddr = 32'h0;
        @(posedge clk);
        #1;
        bus_idle();
        bus.ahb_hwdata = 32'h999;
        @(negedge clk);
        check("rst_wait_hreadyout_pre", 64'(bus.ahb_hreadyout), 64'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midwait_rst_hreadyout", 64'(bus.ahb_hreadyout), 64'h1);
        check("midwait_rst_hresp", 64'(bus.ahb_hresp), 64'h0);
        check("midwait_rst_pix_valid", 64'(pix_valid), 64'h0);
        check("midwait_rst_cfg_lo", cfg_regs[63:0], 64'h0);
        check("midwait_rst_cfg_hi", cfg_regs[127:64], 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 1'b1, 32'd0, 0);
        xfer(1'b0, 32'hC, 3'd2, 32'h0, 1'b0, 1'b1, 32'h0, 0);
        xfer(1'b1, 32'h0, 3'd2, 32'h4242, 1'b0, 1'b0, 32'h0, 0);
        check("post_rst_push_valid", 64'(pix_valid), 64'h1);
        check("post_rst_push_data", 64'(pix_data), 64'h4242);
        check("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
